weight_preload_buffer: RTL and testbench



---
 rtl/tpu_pkg.sv | 10 +
 rtl/weight_shadow_bank.sv | 21 ++
 rtl/weight_preload_buffer.sv | 70 +++++++
 tb/tb_weight_preload_buffer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types and width helpers for the weight staging path
package tpu_pkg;
  typedef enum logic [1:0] {IDLE, FILL, FULL} wpb_state_t;
  function automatic int row_cnt_w(input int mac_row);
    return (mac_row > 1) ? $clog2(mac_row) : 1;
  endfunction
  function automatic int word_w(input int bits, input int cols);
    return bits * cols;
  endfunction
endpackage

// File: rtl/weight_shadow_bank.sv
// weight_shadow_bank: ROWS x WORD_W register file; ports clk/rst, row write (we/waddr/wdata), bulk copy (load/load_data), flat read-out data
module weight_shadow_bank #(
  parameter int ROWS   = 16,
  parameter int WORD_W = 128,
  parameter int AW     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WORD_W-1:0]      wdata,
  input  logic                   load,
  input  logic [ROWS*WORD_W-1:0] load_data,
  output logic [ROWS*WORD_W-1:0] data
);
  always_ff @(posedge clk)
    for (int r = 0; r < ROWS; r++)
      if (rst) data[r*WORD_W +: WORD_W] <= '0;
      else if (load) data[r*WORD_W +: WORD_W] <= load_data[r*WORD_W +: WORD_W];
      else if (we && waddr == AW'(r)) data[r*WORD_W +: WORD_W] <= wdata;
endmodule

// File: rtl/weight_preload_buffer.sv
// weight_preload_buffer: double-buffered weight staging; ins prefetch/read_en/data/ifmap_start, outs active weights, load pulse, shadow_full, sticky overflow/underrun
module weight_preload_buffer
  import tpu_pkg::*;
#(
  parameter int MAC_ROW    = 16,
  parameter int MAC_COL    = 16,
  parameter int W_BITWIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    w_prefetch_in,
  input  logic                                    w_read_en_in,
  input  logic [W_BITWIDTH*MAC_COL-1:0]           w_data_in,
  input  logic                                    ifmap_start_in,
  output logic [W_BITWIDTH*MAC_COL*MAC_ROW-1:0]   w_active_out,
  output logic                                    w_load_out,
  output logic                                    shadow_full_out,
  output logic                                    overflow_err_out,
  output logic                                    underrun_err_out
);
  localparam int ROW_CNT_W = row_cnt_w(MAC_ROW);
  localparam int W_WORD_W  = word_w(W_BITWIDTH, MAC_COL);
  wpb_state_t state, state_next;
  logic [ROW_CNT_W-1:0] row_cnt;
  logic cap_valid;
  logic [W_WORD_W-1:0] cap_data;
  logic [MAC_ROW*W_WORD_W-1:0] shadow_data;
  logic wr, swap, last_row, overflow, underrun;
  always_ff @(posedge clk) state <= rst ? IDLE : state_next;
  // a prefetch always wins: it restarts the fill even while a swap leaves FULL
  always_comb begin
    state_next = w_prefetch_in ? FILL :
                 swap ? IDLE :
                 (wr && last_row) ? FULL : state;
  end
  // a capture coinciding with a prefetch belongs to the superseded request
  always_comb begin
    wr              = cap_valid && !w_prefetch_in && state == FILL;
    overflow        = cap_valid && !w_prefetch_in && state != FILL;
    swap            = ifmap_start_in && state == FULL;
    underrun        = ifmap_start_in && state != FULL;
    last_row        = row_cnt == ROW_CNT_W'(MAC_ROW - 1);
    shadow_full_out = state == FULL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_valid        <= 1'b0;
      cap_data         <= '0;
      row_cnt          <= '0;
      w_load_out       <= 1'b0;
      overflow_err_out <= 1'b0;
      underrun_err_out <= 1'b0;
    end else begin
      cap_valid        <= w_read_en_in;
      cap_data         <= w_data_in;
      row_cnt          <= w_prefetch_in ? '0 : wr ? (last_row ? '0 : row_cnt + 1'b1) : row_cnt;
      w_load_out       <= swap;
      overflow_err_out <= overflow_err_out | overflow;
      underrun_err_out <= underrun_err_out | underrun;
    end
  end
  weight_shadow_bank #(.ROWS(MAC_ROW), .WORD_W(W_WORD_W), .AW(ROW_CNT_W)) u_shadow (
    .clk(clk), .rst(rst), .we(wr), .waddr(row_cnt), .wdata(cap_data),
    .load(1'b0), .load_data('0), .data(shadow_data)
  );
  weight_shadow_bank #(.ROWS(MAC_ROW), .WORD_W(W_WORD_W), .AW(ROW_CNT_W)) u_active (
    .clk(clk), .rst(rst), .we(1'b0), .waddr('0), .wdata('0),
    .load(swap), .load_data(shadow_data), .data(w_active_out)
  );
endmodule

// File: tb/tb_weight_preload_buffer.sv
// tb_weight_preload_buffer: directed scenarios plus random traffic against a tile-level reference model
module tb_weight_preload_buffer;
  localparam int R = 16, C = 16, WB = 8, WW = WB * C, AWID = R * WW;
  logic clk = 1'b0, rst, pf, re, st;
  logic [WW-1:0] d;
  logic [AWID-1:0] active;
  logic load, full, ov, un;
  int n_cmp = 0, n_bad = 0;
  int m_mode, m_cnt;
  logic m_load, m_ov, m_un, m_pend;
  logic [WW-1:0] m_pd;
  logic [WW-1:0] m_sh [R];
  logic [AWID-1:0] m_act;
  weight_preload_buffer #(.MAC_ROW(R), .MAC_COL(C), .W_BITWIDTH(WB)) dut (
    .clk(clk), .rst(rst), .w_prefetch_in(pf), .w_read_en_in(re), .w_data_in(d),
    .ifmap_start_in(st), .w_active_out(active), .w_load_out(load),
    .shadow_full_out(full), .overflow_err_out(ov), .underrun_err_out(un)
  );
  always #5 clk = ~clk;
  function automatic logic [WW-1:0] word_of(input logic [7:0] b);
    return {C{b}};
  endfunction
  function automatic logic [AWID-1:0] tile(input logic [7:0] base);
    logic [AWID-1:0] t;
    for (int r = 0; r < R; r++) t[r*WW +: WW] = word_of(base + 8'(r));
    return t;
  endfunction
  function automatic int first_diff(input logic [AWID-1:0] a, input logic [AWID-1:0] b);
    for (int r = 0; r < R; r++) if (a[r*WW +: WW] !== b[r*WW +: WW]) return r;
    return 0;
  endfunction
  // Reference model: modes 0 idle / 1 filling / 2 tile complete, one captured word per
  // read issued the cycle before; advanced once per clock edge with the inputs of that edge.
  task automatic step(input logic r_, input logic p_, input logic e_, input logic s_, input logic [WW-1:0] d_);
    int old;
    rst = r_; pf = p_; re = e_; st = s_; d = d_;
    @(posedge clk);
    old = m_mode;
    if (r_) begin
      m_mode = 0; m_cnt = 0; m_load = 0; m_ov = 0; m_un = 0; m_pend = 0; m_act = '0;
      for (int i = 0; i < R; i++) m_sh[i] = '0;
    end else begin
      m_load = 0;
      if (s_) begin
        if (old == 2) begin
          for (int i = 0; i < R; i++) m_act[i*WW +: WW] = m_sh[i];
          m_load = 1; m_mode = 0;
        end else m_un = 1;
      end
      if (p_) begin
        m_mode = 1; m_cnt = 0;
      end else if (m_pend) begin
        if (old == 1) begin
          m_sh[m_cnt] = m_pd; m_cnt++;
          if (m_cnt == R) begin m_mode = 2; m_cnt = 0; end
        end else m_ov = 1;
      end
      m_pend = e_; m_pd = d_;
    end
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, '0);
  endtask
  task automatic test_reset();
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 8; i++) step(0, ($urandom % 4) == 0, 1, ($urandom % 3) == 0, {4{$urandom}});
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 1, {4{$urandom}});
      n_cmp++;
      if ({load, full, ov, un} !== 4'b0 || active !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc%0d: got load/full/ov/un=%b active_nonzero=%b required 0000/0", i, {load, full, ov, un}, |active);
      end
    end
    idle();
  endtask
  task automatic test_fill_swap();
    step(0, 1, 0, 0, '0);
    for (int r = 0; r < R; r++) step(0, 0, 1, 0, word_of(8'(r)));
    n_cmp++;
    if (full !== 1'b0) begin n_bad++; $display("FAIL fill_early_full: got %b required 0", full); end
    idle();
    n_cmp++;
    if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full_cycle18: got %b required 1", full); end
    step(0, 0, 0, 1, '0);
    n_cmp++;
    if (load !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL swap_pulse: got load=%b full=%b required 1 0", load, full); end
    n_cmp++;
    if (active !== tile(8'h00)) begin
      n_bad++;
      $display("FAIL swap_active row%0d: got %h required %h", first_diff(active, tile(8'h00)),
               active[first_diff(active, tile(8'h00))*WW +: WW], word_of(8'(first_diff(active, tile(8'h00)))));
    end
    idle();
    n_cmp++;
    if (load !== 1'b0) begin n_bad++; $display("FAIL swap_pulse_len: got %b required 0", load); end
  endtask
  task automatic test_back_to_back();
    logic stable = 1'b1;
    step(0, 1, 0, 0, '0);
    for (int r = 0; r < R; r++) step(0, 0, 1, 0, word_of(8'hA0 + 8'(r)));
    idle();
    step(0, 1, 0, 1, '0);
    n_cmp++;
    if (load !== 1'b1 || active !== tile(8'hA0)) begin n_bad++; $display("FAIL overlap_swap: got load=%b row0=%h required 1 %h", load, active[WW-1:0], word_of(8'hA0)); end
    for (int r = 0; r < R; r++) begin
      step(0, 0, 1, 0, word_of(8'hB0 + 8'(r)));
      if (active !== tile(8'hA0)) stable = 1'b0;
    end
    idle();
    n_cmp++;
    if (!stable) begin n_bad++; $display("FAIL overlap_active_during_fill: got changed required tile A"); end
    n_cmp++;
    if ({full, ov, un} !== 3'b100) begin n_bad++; $display("FAIL overlap_flags: got full/ov/un=%b required 100", {full, ov, un}); end
    step(0, 0, 0, 1, '0);
    n_cmp++;
    if (active !== tile(8'hB0)) begin n_bad++; $display("FAIL overlap_second_swap row%0d: got %h required %h", first_diff(active, tile(8'hB0)), active[first_diff(active, tile(8'hB0))*WW +: WW], word_of(8'hB0 + 8'(first_diff(active, tile(8'hB0))))); end
    idle();
  endtask
  task automatic test_underrun();
    step(0, 1, 0, 0, '0);
    for (int r = 0; r < 10; r++) step(0, 0, 1, 0, word_of(8'hC0 + 8'(r)));
    step(0, 0, 0, 1, '0);
    n_cmp++;
    if (un !== 1'b1 || load !== 1'b0 || active !== tile(8'hB0)) begin n_bad++; $display("FAIL underrun: got un=%b load=%b row0=%h required 1 0 %h", un, load, active[WW-1:0], word_of(8'hB0)); end
    for (int r = 10; r < R; r++) step(0, 0, 1, 0, word_of(8'hC0 + 8'(r)));
    idle();
    n_cmp++;
    if (full !== 1'b1) begin n_bad++; $display("FAIL underrun_fill_continues: got full=%b required 1", full); end
    step(0, 0, 0, 1, '0);
    n_cmp++;
    if (active !== tile(8'hC0)) begin n_bad++; $display("FAIL underrun_tile row%0d: got %h required %h", first_diff(active, tile(8'hC0)), active[first_diff(active, tile(8'hC0))*WW +: WW], word_of(8'hC0 + 8'(first_diff(active, tile(8'hC0))))); end
    idle();
  endtask
  task automatic test_overflow();
    step(0, 1, 0, 0, '0);
    for (int r = 0; r < R + 1; r++) step(0, 0, 1, 0, word_of(8'hD0 + 8'(r)));
    n_cmp++;
    if (full !== 1'b1 || ov !== 1'b0) begin n_bad++; $display("FAIL overflow_before: got full=%b ov=%b required 1 0", full, ov); end
    idle();
    n_cmp++;
    if (ov !== 1'b1 || full !== 1'b1) begin n_bad++; $display("FAIL overflow_17th: got ov=%b full=%b required 1 1", ov, full); end
    step(0, 0, 0, 1, '0);
    n_cmp++;
    if (active[(R-1)*WW +: WW] !== word_of(8'hDF) || active !== tile(8'hD0)) begin n_bad++; $display("FAIL overflow_row15: got %h required %h", active[(R-1)*WW +: WW], word_of(8'hDF)); end
    idle();
  endtask
  task automatic test_reset_midfill();
    step(0, 1, 0, 0, '0);
    for (int r = 0; r < 5; r++) step(0, 0, 1, 0, word_of(8'hEE));
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);
    for (int r = 0; r < R; r++) step(0, 0, 1, 0, word_of(8'h10 + 8'(r)));
    idle();
    n_cmp++;
    if (full !== 1'b1) begin n_bad++; $display("FAIL midreset_full: got %b required 1", full); end
    step(0, 0, 0, 1, '0);
    n_cmp++;
    if (active !== tile(8'h10) || ov !== 1'b0 || un !== 1'b0) begin n_bad++; $display("FAIL midreset_tile: got row%0d=%h ov=%b un=%b required %h 0 0", first_diff(active, tile(8'h10)), active[first_diff(active, tile(8'h10))*WW +: WW], ov, un, word_of(8'h10 + 8'(first_diff(active, tile(8'h10))))); end
    idle();
  endtask
  task automatic test_random();
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 250) == 0, ($urandom % 22) == 0, ($urandom % 4) != 0, ($urandom % 14) == 0, {$urandom, $urandom, $urandom, $urandom});
      n_cmp++;
      if (load !== m_load || full !== (m_mode == 2) || ov !== m_ov || un !== m_un || active !== m_act) begin
        n_bad++;
        $display("FAIL random cyc%0d: got load/full/ov/un=%b%b%b%b row%0d=%h required %b%b%b%b %h", i, load, full, ov, un,
                 first_diff(active, m_act), active[first_diff(active, m_act)*WW +: WW],
                 m_load, m_mode == 2, m_ov, m_un, m_act[first_diff(active, m_act)*WW +: WW]);
      end
    end
  endtask
  initial begin
    m_mode = 0; m_cnt = 0; m_load = 0; m_ov = 0; m_un = 0; m_pend = 0; m_pd = '0; m_act = '0;
    for (int i = 0; i < R; i++) m_sh[i] = '0;
    test_reset();
    test_fill_swap();
    test_back_to_back();
    test_underrun();
    test_overflow();
    test_reset_midfill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
